alu_execute_unit: RTL and testbench
===================================

# alu_execute_unit

Execute stage directly downstream of the register file. It latches the two operands presented on the register file read buses together with an opcode and a destination address, and computes the result. Single-cycle ops finish in one cycle; MUL runs as an iterative shift-add over several cycles. The result goes back to the register file write port as a one-cycle write pulse, and a status-flag register is updated.

## Interface
- REG_WIDTH, 8, operand/result width; matches register file word width
- ADDR_WIDTH, 5, destination address width; matches register file address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- issue_valid  in  1  issuer presents an operation this cycle
- issue_ready  out  1  unit can accept; high only in IDLE
- opcode  in  4  operation select (encoding below)
- operand_a  in  REG_WIDTH  from register file read bus 1
- operand_b  in  REG_WIDTH  from register file read bus 2
- dest_addr  in  ADDR_WIDTH  destination register
- write_bus  out  REG_WIDTH  result to register file
- write_addr  out  ADDR_WIDTH  destination to register file
- write_enabled  out  1  one-cycle write strobe to register file
- flags  out  4  {N, Z, C, V}, registered

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (a−b)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT a
  - 6 SHL a by 1
  - 7 SHR a by 1 (logical)
  - 8 MUL (low REG_WIDTH bits of a×b)
  - 9 CMP (a−b, flags only, no write)
  - 10–15 reserved
- Accept on the rising edge where issue_valid && issue_ready. Operands, opcode and dest_addr are captured at that edge. Inputs are don't-care at other times.
- All results are truncated to REG_WIDTH bits.
- Flags are updated on the edge that produces a result, and on CMP:
  - N = result MSB
  - Z = result==0
  - C = carry-out for ADD; borrow for SUB/CMP (1 when a<b unsigned); bit shifted out for SHL/SHR; 1 for MUL if the upper product half ≠0; 0 for logic ops
  - V = signed overflow for ADD/SUB/CMP; 0 otherwise
- Reserved opcodes: accepted and consumed; no write; flags unchanged.
- State machine:
  - IDLE: on accept of a non-MUL op, stay in IDLE. On accept of MUL, go to MUL_RUN.
  - MUL_RUN: iteration counter counts REG_WIDTH iterations. On the last iteration, register the result, pulse the write, and return to IDLE.
- No forwarding. The issuer must not issue an op reading dest_addr until the write pulse has been seen.

## Timing
- Reset values: issue_ready=1, write_enabled=0, write_bus=0, write_addr=0, flags=0, state=IDLE, counter=0.
- Single-cycle op accepted at edge E0:
  - write_enabled=1 with result and address for exactly the cycle following E0
  - flags valid from that same cycle
- Back-to-back single-cycle ops may be accepted every cycle. write_enabled then stays high across consecutive cycles, with a new address and data each cycle.
- MUL accepted at E0:
  - issue_ready=0 from after E0 until after E_REG_WIDTH
  - write_enabled=1 in the single cycle after E_REG_WIDTH
  - issue_ready returns high in that same cycle, so the next op can be accepted at E_REG_WIDTH+1
- write_enabled is deasserted in every cycle that carries no result: CMP, reserved opcodes, MUL_RUN cycles before completion.
- reset asserted mid-MUL: the operation is aborted immediately and no write occurs. After reset release the unit is in IDLE.
- A DEST of register 0 is written like any other register; this unit applies no special-casing.

## Structure
- Shared package/header (alu_defs) holds:
  - opcode constants
  - state encoding
  - flag bit indices {N=3, Z=2, C=1, V=0}
- Sub-module shift_add_multiplier:
  - inputs: start, a, b
  - outputs: busy, done, product
  - internal REG_WIDTH-bit counter; shift-add, one bit per cycle
- The top level holds the combinational single-cycle datapath, the flag logic, the FSM, and the output registers.

## Test plan
- ADD a=8'h7F, b=8'h01, dest=3 → write_enabled one cycle later, write_bus=8'h80, write_addr=3, flags N=1 Z=0 C=0 V=1.
- SUB a=8'h05, b=8'h05, then CMP a=8'h02, b=8'h03 on consecutive cycles:
  - two accepts, one write: 8'h00 with Z=1 C=0
  - then flags N=1 C=1 Z=0, with no second write pulse
- MUL a=8'h0D, b=8'h0B, dest=7 → issue_ready low for 8 cycles; a single write of 8'h8F with C=0 appears 8 cycles after accept; issue_ready high that cycle.
- MUL a=8'hFF, b=8'h02 → write_bus=8'hFE, C=1. A SHL issued while ready=0 is not accepted; it is accepted on the cycle after the MUL write.
- reset asserted 4 cycles into a MUL → outputs return to reset values at once. No write occurs after release. The next ADD 1+1 writes 8'h02.
- Opcode 12 followed by XOR 8'hAA^8'hFF → no write and flags unchanged for opcode 12; then write_bus=8'h55, Z=0, N=0.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// alu_defs_pkg
//   Shared definitions for the ALU execute stage: opcode encodings, the
//   execute FSM state type, flag bit positions inside the {N,Z,C,V} flag
//   vector, and a helper that packs individual flag bits into that vector.
package alu_defs_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Places each flag at its fixed index so callers never depend on the
  // ordering of the flag vector.
  function automatic logic [3:0] packFlags(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_execute_unit_shift_add_multiplier.sv
// shift_add_multiplier
//   Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
//   Ports:
//     i_clk, i_rst_n     clock, asynchronous active-low reset
//     i_start            capture i_a/i_b and begin (ignored while busy)
//     i_a, i_b           REG_WIDTH-bit operands
//     o_busy             an iteration is in progress
//     o_done             the current cycle performs the final iteration
//     o_product          full 2*REG_WIDTH product after this cycle's iteration
module shift_add_multiplier #(
  parameter int REG_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [REG_WIDTH-1:0]   i_a,
  input  logic [REG_WIDTH-1:0]   i_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [2*REG_WIDTH-1:0] o_product
);

  localparam logic [REG_WIDTH-1:0] LAST_ITER = REG_WIDTH'(REG_WIDTH - 1);

  logic                   r_busy;
  logic [REG_WIDTH-1:0]   r_count;
  logic [2*REG_WIDTH-1:0] r_acc;
  logic [2*REG_WIDTH-1:0] r_mcand;
  logic [REG_WIDTH-1:0]   r_mplier;
  logic [2*REG_WIDTH-1:0] w_partial;

  // o_product is the accumulator including this cycle's partial product, so
  // the owner can register the final result on the same edge as the last
  // iteration instead of waiting an extra cycle.
  assign w_partial = r_mplier[0] ? r_mcand : '0;
  assign o_product = r_acc + w_partial;
  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_count == LAST_ITER);

  // Multiplicand shifts left and multiplier shifts right each iteration;
  // the counter ends the run after exactly REG_WIDTH iterations.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start && !r_busy) begin
      r_busy   <= 1'b1;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= {{REG_WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= o_product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) begin
        r_busy  <= 1'b0;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_execute_unit.sv
// alu_execute_unit
//   Execute stage behind the register file. Single-cycle ops write back on
//   the cycle after acceptance; MUL runs on the shift-add multiplier and
//   writes back REG_WIDTH cycles later. Flags {N,Z,C,V} are registered.
//   Ports:
//     i_clk, i_rst_n                clock, asynchronous active-low reset
//     i_issue_valid/o_issue_ready   issue handshake (ready only in IDLE)
//     i_opcode, i_operand_a/b       operation and register file read data
//     i_dest_addr                   destination register
//     o_write_bus/addr/enabled      register file write port, one-cycle strobe
//     o_flags                       {N,Z,C,V}
module alu_execute_unit
  import alu_defs_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_issue_valid,
  output logic                  o_issue_ready,
  input  logic [3:0]            i_opcode,
  input  logic [REG_WIDTH-1:0]  i_operand_a,
  input  logic [REG_WIDTH-1:0]  i_operand_b,
  input  logic [ADDR_WIDTH-1:0] i_dest_addr,
  output logic [REG_WIDTH-1:0]  o_write_bus,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic                  o_write_enabled,
  output logic [3:0]            o_flags
);

  localparam int MSB = REG_WIDTH - 1;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_mulDest;
  logic [REG_WIDTH-1:0]    r_writeBus;
  logic [ADDR_WIDTH-1:0]   r_writeAddr;
  logic                    r_writeEn;
  logic [3:0]              r_flags;

  logic                    w_accept;
  logic                    w_mulStart;
  logic                    w_mulBusy;
  logic                    w_mulDone;
  logic [2*REG_WIDTH-1:0]  w_mulProduct;
  logic [REG_WIDTH-1:0]    w_mulResult;
  logic [3:0]              w_mulFlags;
  logic [REG_WIDTH:0]      w_sum;
  logic [REG_WIDTH:0]      w_diff;
  logic [REG_WIDTH-1:0]    w_result;
  logic                    w_carry;
  logic                    w_overflow;
  logic [3:0]              w_singleFlags;

  assign o_issue_ready   = (r_state == ST_IDLE) && !w_mulBusy;
  assign w_accept        = i_issue_valid && o_issue_ready;
  assign w_mulStart      = w_accept && (i_opcode == OP_MUL);
  assign o_write_bus     = r_writeBus;
  assign o_write_addr    = r_writeAddr;
  assign o_write_enabled = r_writeEn;
  assign o_flags         = r_flags;

  shift_add_multiplier #(.REG_WIDTH(REG_WIDTH)) u_mul (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_mulStart),
    .i_a       (i_operand_a),
    .i_b       (i_operand_b),
    .o_busy    (w_mulBusy),
    .o_done    (w_mulDone),
    .o_product (w_mulProduct)
  );

  // The extra top bit of the widened sum/difference is carry-out and borrow.
  assign w_sum  = {1'b0, i_operand_a} + {1'b0, i_operand_b};
  assign w_diff = {1'b0, i_operand_a} - {1'b0, i_operand_b};

  // Single-cycle datapath, evaluated on the operands as presented so the
  // accepting edge both captures and commits the result.
  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_result   = w_sum[MSB:0];
        w_carry    = w_sum[REG_WIDTH];
        w_overflow = (i_operand_a[MSB] == i_operand_b[MSB]) &&
                     (w_sum[MSB] != i_operand_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        w_result   = w_diff[MSB:0];
        w_carry    = w_diff[REG_WIDTH];
        w_overflow = (i_operand_a[MSB] != i_operand_b[MSB]) &&
                     (w_diff[MSB] != i_operand_a[MSB]);
      end
      OP_AND: w_result = i_operand_a & i_operand_b;
      OP_OR:  w_result = i_operand_a | i_operand_b;
      OP_XOR: w_result = i_operand_a ^ i_operand_b;
      OP_NOT: w_result = ~i_operand_a;
      OP_SHL: begin
        w_result = {i_operand_a[MSB-1:0], 1'b0};
        w_carry  = i_operand_a[MSB];
      end
      OP_SHR: begin
        w_result = {1'b0, i_operand_a[MSB:1]};
        w_carry  = i_operand_a[0];
      end
      default: ;
    endcase
  end

  assign w_singleFlags = packFlags(w_result[MSB], (w_result == '0), w_carry, w_overflow);
  assign w_mulResult   = w_mulProduct[MSB:0];
  assign w_mulFlags    = packFlags(w_mulResult[MSB], (w_mulResult == '0),
                                   |w_mulProduct[2*REG_WIDTH-1:REG_WIDTH], 1'b0);

  // Execute FSM and output registers. The write strobe defaults low every
  // cycle so it is a single pulse per result; CMP and reserved opcodes
  // never raise it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_mulDest   <= '0;
      r_writeBus  <= '0;
      r_writeAddr <= '0;
      r_writeEn   <= 1'b0;
      r_flags     <= '0;
    end else begin
      r_writeEn <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (i_opcode)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                r_writeBus  <= w_result;
                r_writeAddr <= i_dest_addr;
                r_writeEn   <= 1'b1;
                r_flags     <= w_singleFlags;
              end
              OP_CMP: r_flags <= w_singleFlags;
              OP_MUL: begin
                r_mulDest <= i_dest_addr;
                r_state   <= ST_MUL_RUN;
              end
              default: ;
            endcase
          end
        end
        ST_MUL_RUN: begin
          if (w_mulDone) begin
            r_writeBus  <= w_mulResult;
            r_writeAddr <= r_mulDest;
            r_writeEn   <= 1'b1;
            r_flags     <= w_mulFlags;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// tb_alu_execute_unit
//   Self-checking bench: directed scenarios followed by a random op stream,
//   each checked against a transaction-level reference model.
module tb_alu_execute_unit;

  logic       clk = 1'b0;
  logic       rstN;
  logic       issueValid;
  logic       issueReady;
  logic [3:0] opcode;
  logic [7:0] operandA;
  logic [7:0] operandB;
  logic [4:0] destAddr;
  logic [7:0] writeBus;
  logic [4:0] writeAddr;
  logic       writeEnabled;
  logic [3:0] flags;

  int         numChecks = 0;
  int         numErrors = 0;
  logic [3:0] expFlags  = 4'h0;

  alu_execute_unit #(.REG_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_issue_valid   (issueValid),
    .o_issue_ready   (issueReady),
    .i_opcode        (opcode),
    .i_operand_a     (operandA),
    .i_operand_b     (operandB),
    .i_dest_addr     (destAddr),
    .o_write_bus     (writeBus),
    .o_write_addr    (writeAddr),
    .o_write_enabled (writeEnabled),
    .o_flags         (flags)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one issue slot; no time passes here.
  task automatic applyStimulus(input logic valid, input logic [3:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [4:0] dest);
    issueValid = valid;
    opcode     = op;
    operandA   = a;
    operandB   = b;
    destAddr   = dest;
  endtask

  // Advances to 1 ns after the next rising edge, where outputs are sampled
  // and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one operation, from the arithmetic definitions.
  task automatic refModel(input int op, input int a, input int b,
                          output bit wr, output bit upd, output int res,
                          output logic [3:0] flg);
    int sa, sb, s, raw, c, v;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = 0; v = 0; raw = 0;
    case (op)
      0: begin raw = a + b; c = (raw > 255); s = sa + sb; v = (s > 127 || s < -128); end
      1, 9: begin raw = a - b; c = (a < b); s = sa - sb; v = (s > 127 || s < -128); end
      2: raw = a & b;
      3: raw = a | b;
      4: raw = a ^ b;
      5: raw = 255 - a;
      6: begin raw = a * 2; c = (raw > 255); end
      7: begin raw = a / 2; c = a % 2; end
      8: begin raw = a * b; c = (raw > 255); end
      default: raw = 0;
    endcase
    res = raw & 255;
    wr  = (op <= 8);
    upd = (op <= 9);
    flg = {res >= 128, res == 0, c != 0, v != 0};
  endtask

  // Issues one op at the current sample point and checks it through to
  // its result cycle. During a MUL a different op is held valid to confirm
  // it is not accepted while the unit is busy.
  task automatic runOp(input int op, input int a, input int b, input int dest);
    bit         wr, upd;
    int         res;
    logic [3:0] flg;
    refModel(op, a, b, wr, upd, res, flg);
    applyStimulus(1'b1, op[3:0], a[7:0], b[7:0], dest[4:0]);
    tick();
    if (op == 8) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 5'($urandom));
      for (int k = 0; k < 8; k++) begin
        checkOutput("mulReadyLow", {31'd0, issueReady}, 32'd0);
        checkOutput("mulNoWrite", {31'd0, writeEnabled}, 32'd0);
        checkOutput("mulFlagsHeld", {28'd0, flags}, {28'd0, expFlags});
        tick();
      end
    end
    checkOutput("writeEnable", {31'd0, writeEnabled}, {31'd0, wr});
    if (wr) begin
      checkOutput("writeBus", {24'd0, writeBus}, res);
      checkOutput("writeAddr", {27'd0, writeAddr}, dest);
    end
    if (upd) expFlags = flg;
    checkOutput("flags", {28'd0, flags}, {28'd0, expFlags});
    checkOutput("issueReady", {31'd0, issueReady}, 32'd1);
    issueValid = 1'b0;
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 4'd0, 8'd0, 8'd0, 5'd0);
    #3;
    checkOutput("resetReady", {31'd0, issueReady}, 32'd1);
    checkOutput("resetWe", {31'd0, writeEnabled}, 32'd0);
    checkOutput("resetBus", {24'd0, writeBus}, 32'd0);
    checkOutput("resetAddr", {27'd0, writeAddr}, 32'd0);
    checkOutput("resetFlags", {28'd0, flags}, 32'd0);
    tick();
    rstN = 1'b1;
    tick();

    // ADD with signed overflow into the sign bit
    runOp(0, 8'h7F, 8'h01, 3);
    // SUB to zero immediately followed by CMP (flags only)
    runOp(1, 8'h05, 8'h05, 4);
    runOp(9, 8'h02, 8'h03, 9);
    checkOutput("cmpNoTrailingWrite", {31'd0, writeEnabled}, 32'd0);
    tick();
    checkOutput("idleNoWrite", {31'd0, writeEnabled}, 32'd0);
    // Multiplies, the second overflowing; SHL right after the MUL write
    runOp(8, 8'h0D, 8'h0B, 7);
    runOp(8, 8'hFF, 8'h02, 11);
    runOp(6, 8'h81, 8'h00, 12);
    // Register 0 is an ordinary destination
    runOp(3, 8'h0F, 8'hF0, 0);

    // Reset four cycles into a MUL aborts it without a write
    applyStimulus(1'b1, 4'd8, 8'h33, 8'h44, 5'd5);
    tick();
    issueValid = 1'b0;
    repeat (4) tick();
    rstN = 1'b0;
    #1;
    checkOutput("abortReady", {31'd0, issueReady}, 32'd1);
    checkOutput("abortWe", {31'd0, writeEnabled}, 32'd0);
    checkOutput("abortBus", {24'd0, writeBus}, 32'd0);
    checkOutput("abortAddr", {27'd0, writeAddr}, 32'd0);
    checkOutput("abortFlags", {28'd0, flags}, 32'd0);
    expFlags = 4'h0;
    tick();
    rstN = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("postAbortNoWrite", {31'd0, writeEnabled}, 32'd0);
    end
    runOp(0, 8'h01, 8'h01, 2);

    // Reserved opcode leaves flags alone, then XOR
    runOp(12, 8'h12, 8'h34, 6);
    runOp(4, 8'hAA, 8'hFF, 8);

    // Random back-to-back stream over all opcodes
    for (int n = 0; n < 250; n++) begin
      runOp(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 31)));
    end
    tick();
    checkOutput("finalNoWrite", {31'd0, writeEnabled}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
    $finish;
  end

endmodule
